// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - MEM-stage memory sequencer and global pipeline freeze
module mem_stall_ctrl #(
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             cache_hit,
    input  logic [31:0]      addr,
    input  logic             mem_ready,
    output logic             freeze,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_idx,
    output logic             busy,
    output logic [31:0]      stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
    localparam int               BLK_LSB  = IDX_W + 2;

    state_t                state;
    logic [31:BLK_LSB]     blk_q;       // block-aligned part of the latched address
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_next;
    logic                  req_q;
    logic                  we_q;
    logic                  busy_q;
    logic [31:0]           addr_out_q;
    logic [31:0]           stall_q;
    logic                  freeze_int;

    assign idx_next = idx_q + IDX_W'(1);

    // Freeze decode: IDLE reacts to the incoming access in the same cycle, FILL/WRITE always stall
    always_comb begin
        freeze_int = 1'b0;
        case (state)
            IDLE:    freeze_int = mem_write | (mem_read & ~cache_hit);
            FILL:    freeze_int = 1'b1;
            WRITE:   freeze_int = 1'b1;
            default: freeze_int = 1'b0;
        endcase
    end

    // The IDLE term is combinational on inputs, so hold it low while reset is asserted
    assign freeze      = freeze_int & rst_b;
    assign fill_we     = (state == FILL) & mem_ready;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_out_q;
    assign busy        = busy_q;
    assign fill_idx    = idx_q;
    assign stall_count = stall_q;

    // Sequencer with registered request/address outputs set alongside each transition
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            blk_q      <= '0;
            idx_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            addr_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        state      <= WRITE;
                        blk_q      <= addr[31:BLK_LSB];
                        req_q      <= 1'b1;
                        we_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        addr_out_q <= addr;
                    end else if (mem_read && !cache_hit) begin
                        state      <= FILL;
                        blk_q      <= addr[31:BLK_LSB];
                        idx_q      <= '0;
                        req_q      <= 1'b1;
                        we_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        addr_out_q <= {addr[31:BLK_LSB], {IDX_W{1'b0}}, 2'b00};
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        // Index wraps to 0 after the last word; it is ignored outside FILL
                        idx_q <= idx_next;
                        if (idx_q == LAST_IDX) begin
                            state      <= DONE;
                            req_q      <= 1'b0;
                            addr_out_q <= '0;
                        end else begin
                            addr_out_q <= {blk_q, idx_next, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state      <= DONE;
                        req_q      <= 1'b0;
                        we_q       <= 1'b0;
                        addr_out_q <= '0;
                    end
                end
                default: begin
                    // DONE: pipeline advances this edge; inputs deliberately not sampled
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of frozen cycles for performance reporting
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_q <= '0;
        end else if (freeze && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - scoreboard bench for mem_stall_ctrl
module tb_mem_stall_ctrl;

    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        mem_read, mem_write, cache_hit, mem_ready;
    logic [31:0] addr;
    logic        freeze, mem_req, mem_we, fill_we, busy;
    logic [31:0] mem_addr, stall_count;
    logic [1:0]  fill_idx;

    mem_stall_ctrl #(.BLOCK_WORDS(BW), .IDX_W(2)) dut (
        .clk(clk), .rst_b(rst_b), .mem_read(mem_read), .mem_write(mem_write),
        .cache_hit(cache_hit), .addr(addr), .mem_ready(mem_ready),
        .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .fill_we(fill_we), .fill_idx(fill_idx), .busy(busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        frz;
        logic        req;
        logic        we;
        logic        fwe;
        logic        bsy;
        logic [31:0] a;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [31:0] model_stall = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic r, input logic w,
                                input logic fw, input logic b, input logic [31:0] a);
        exp_t e;
        e.frz = f; e.req = r; e.we = w; e.fwe = fw; e.bsy = b; e.a = a;
        return e;
    endfunction

    // Monitor: pops one expected cycle and compares at the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (chk_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("freeze",  {31'd0, freeze},  {31'd0, e.frz});
            check("mem_req", {31'd0, mem_req}, {31'd0, e.req});
            check("mem_we",  {31'd0, mem_we},  {31'd0, e.we});
            check("fill_we", {31'd0, fill_we}, {31'd0, e.fwe});
            check("busy",    {31'd0, busy},    {31'd0, e.bsy});
            if (e.req) check("mem_addr", mem_addr, e.a);
        end
    end

    // Queue the expectation for the current cycle, then advance one clock
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        if (e.frz && model_stall != 32'hFFFF_FFFF) model_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic load_miss(input logic [31:0] a, input int wfix);
        logic [31:0] base;
        int w;
        base = a & ~32'hF;
        mem_read = 1'b1; mem_write = 1'b0; cache_hit = 1'b0; addr = a;
        mem_ready = 1'($urandom);
        step(mk(1, 0, 0, 0, 0, 0));
        for (int i = 0; i < BW; i++) begin
            w = (wfix >= 0) ? wfix : int'($urandom_range(3));
            mem_ready = 1'b0;
            for (int j = 0; j < w; j++) step(mk(1, 1, 0, 0, 1, base + 32'(i * 4)));
            mem_ready = 1'b1;
            step(mk(1, 1, 0, 1, 1, base + 32'(i * 4)));
        end
        cache_hit = 1'b1; mem_ready = 1'($urandom);
        step(mk(0, 0, 0, 0, 1, 0));
    endtask

    task automatic store(input logic [31:0] a, input int w, input logic rd);
        mem_write = 1'b1; mem_read = rd; cache_hit = 1'($urandom); addr = a;
        mem_ready = 1'($urandom);
        step(mk(1, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        for (int j = 0; j < w; j++) step(mk(1, 1, 1, 0, 1, a));
        mem_ready = 1'b1;
        step(mk(1, 1, 1, 0, 1, a));
        mem_ready = 1'($urandom);
        step(mk(0, 0, 0, 0, 1, 0));
    endtask

    task automatic quiet(input int n, input logic hit_rd);
        for (int k = 0; k < n; k++) begin
            mem_write = 1'b0; mem_read = hit_rd; cache_hit = 1'b1;
            addr = $urandom; mem_ready = 1'($urandom);
            step(mk(0, 0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        logic [31:0] snap;
        rst_b = 1'b0; mem_read = 1'b0; mem_write = 1'b0; cache_hit = 1'b0;
        mem_ready = 1'b0; addr = 32'd0;
        #1;
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_stall",  stall_count,     32'd0);
        check("rst_idx",    {30'd0, fill_idx}, 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        chk_en = 1'b1;

        // Load hits never stall
        snap = model_stall;
        quiet(3, 1'b1);
        check("hit_stall", stall_count, snap);

        // Load miss with immediate memory
        snap = model_stall;
        load_miss(32'h0000_1234, 0);
        check("miss_stall", stall_count, model_stall);
        check("miss_len", model_stall - snap, 32'd5);

        // Load miss with two wait cycles per word
        snap = model_stall;
        load_miss($urandom, 2);
        check("miss_wait_stall", stall_count, model_stall);
        check("miss_wait_len", model_stall - snap, 32'd13);

        // Store with a concurrent load; no re-serve afterwards
        snap = model_stall;
        store(32'h0000_0040, 2, 1'b1);
        quiet(1, 1'b0);
        check("store_len", model_stall - snap, 32'd4);
        check("store_stall", stall_count, model_stall);

        // Back-to-back: store then load miss in the very next IDLE cycle
        store({$urandom} & ~32'h3, 0, 1'b0);
        load_miss($urandom, -1);
        check("b2b_stall", stall_count, model_stall);

        // Randomized mix
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3))
                0: load_miss($urandom, -1);
                1: store({$urandom} & ~32'h3, int'($urandom_range(4)), 1'($urandom));
                2: quiet(int'($urandom_range(1, 3)), 1'b1);
                default: quiet(1, 1'b0);
            endcase
        end
        check("rand_stall", stall_count, model_stall);

        // Asynchronous reset in the middle of a refill
        mem_read = 1'b1; mem_write = 1'b0; cache_hit = 1'b0; addr = $urandom;
        step(mk(1, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        step(mk(1, 1, 0, 0, 1, (addr & ~32'hF)));
        chk_en = 1'b0;
        mem_write = 1'b1; mem_ready = 1'b1;
        #1 rst_b = 1'b0;
        #1;
        check("arst_freeze",  {31'd0, freeze},  32'd0);
        check("arst_req",     {31'd0, mem_req}, 32'd0);
        check("arst_fill_we", {31'd0, fill_we}, 32'd0);
        check("arst_busy",    {31'd0, busy},    32'd0);
        check("arst_stall",   stall_count,      32'd0);
        @(posedge clk); #1;
        check("arst_hold_busy", {31'd0, busy}, 32'd0);
        mem_write = 1'b0; mem_read = 1'b0;
        rst_b = 1'b1;
        model_stall = 32'd0;
        chk_en = 1'b1;
        load_miss($urandom, -1);
        check("post_rst_stall", stall_count, model_stall);

        // Saturation of the stall counter
        force dut.stall_q = 32'hFFFF_FFFE;
        #1 release dut.stall_q;
        model_stall = 32'hFFFF_FFFE;
        store({$urandom} & ~32'h3, 1, 1'b0);
        check("sat_model", model_stall, 32'hFFFF_FFFF);
        check("sat_stall", stall_count, 32'hFFFF_FFFF);

        quiet(2, 1'b0);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
